// File: rtl/layer_collector.sv
// layer_collector: captures one layer's neuron outputs, requantizes them,
// streams them over valid/ready and reports the argmax of the vector.
// Ports: clk, rst_n (async low); capture + neuron_in[] (capture side);
//        busy, out_valid/out_ready/out_data/out_index/out_last (stream);
//        argmax_valid/argmax_idx/argmax_val (result of last full vector).
module layer_collector #(
    parameter int LAYER_DATA_WIDTH = 8,
    parameter int NUM_NEURONS      = 10,
    parameter int FRAC_SHIFT       = 4,
    parameter int IDX_W            = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               capture,
    input  logic signed [LAYER_DATA_WIDTH+7:0] neuron_in [0:NUM_NEURONS-1],
    output logic                               busy,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [LAYER_DATA_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]                   out_index,
    output logic                               out_last,
    output logic                               argmax_valid,
    output logic [IDX_W-1:0]                   argmax_idx,
    output logic signed [LAYER_DATA_WIDTH-1:0] argmax_val
);

    localparam int W  = LAYER_DATA_WIDTH;
    localparam int DW = LAYER_DATA_WIDTH + 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    // Saturation bounds expressed at input width so the compare is exact.
    localparam logic signed [DW-1:0] Q_MAX = {{(DW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [DW-1:0] Q_MIN = {{(DW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [IDX_W-1:0]      r_idx;
    logic signed [W-1:0]   r_buf [0:NUM_NEURONS-1];
    logic signed [W-1:0]   w_q   [0:NUM_NEURONS-1];
    logic signed [W-1:0]   r_max_val;
    logic [IDX_W-1:0]      r_max_idx;
    logic                  r_argmax_valid;
    logic [IDX_W-1:0]      r_argmax_idx;
    logic signed [W-1:0]   r_argmax_val;

    logic                  w_accept;
    logic                  w_fire;
    logic                  w_is_last;
    logic signed [W-1:0]   w_cur;
    logic                  w_take;
    logic signed [W-1:0]   w_new_val;
    logic [IDX_W-1:0]      w_new_idx;

    // Arithmetic shift floors toward -inf; then clamp to the W-bit range.
    always_comb begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            logic signed [DW-1:0] q;
            q = neuron_in[i] >>> FRAC_SHIFT;
            if (q > Q_MAX)
                w_q[i] = Q_MAX[W-1:0];
            else if (q < Q_MIN)
                w_q[i] = Q_MIN[W-1:0];
            else
                w_q[i] = q[W-1:0];
        end
    end

    assign w_accept  = (r_state == S_IDLE) && capture;
    assign w_fire    = (r_state == S_STREAM) && out_ready;
    assign w_is_last = (r_idx == LAST_IDX);
    assign w_cur     = r_buf[r_idx];

    // Strict greater-than keeps the lowest index on ties.
    assign w_take    = (r_idx == '0) || (w_cur > r_max_val);
    assign w_new_val = w_take ? w_cur : r_max_val;
    assign w_new_idx = w_take ? r_idx : r_max_idx;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:   if (capture) w_state_next = S_STREAM;
            S_STREAM: if (out_ready && w_is_last) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx          <= '0;
            r_max_val      <= '0;
            r_max_idx      <= '0;
            r_argmax_valid <= 1'b0;
            r_argmax_idx   <= '0;
            r_argmax_val   <= '0;
        end else if (w_accept) begin
            r_idx          <= '0;
            r_argmax_valid <= 1'b0;
        end else if (w_fire) begin
            r_max_val <= w_new_val;
            r_max_idx <= w_new_idx;
            if (w_is_last) begin
                r_argmax_valid <= 1'b1;
                r_argmax_idx   <= w_new_idx;
                r_argmax_val   <= w_new_val;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Buffer contents are meaningless outside STREAM, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < NUM_NEURONS; i++)
                r_buf[i] <= w_q[i];
        end
    end

    assign busy         = (r_state == S_STREAM);
    assign out_valid    = (r_state == S_STREAM);
    assign out_data     = out_valid ? w_cur : '0;
    assign out_index    = out_valid ? r_idx : '0;
    assign out_last     = out_valid && w_is_last;
    assign argmax_valid = r_argmax_valid;
    assign argmax_idx   = r_argmax_idx;
    assign argmax_val   = r_argmax_val;

endmodule
